// File: rtl/data_memory_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_banked_pkg
// Description : Shared constants for the banked MEM-stage data memory.
//               RV32 load/store funct3 codes and the request FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_banked_pkg;

    // RV32 funct3 codes. Stores reuse B/H/W; BU/HU exist only for loads.
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // Request FSM encoding
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

endpackage : data_memory_banked_pkg
`default_nettype wire

// File: rtl/data_memory_banked_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering for RV32 loads and stores.
//               Produces byte enables and replicated store data, extracts and
//               sign/zero-extends load data, and flags misaligned accesses
//               and funct3 codes that are illegal for the access direction.
// Ports       : i_funct3   access size/sign code
//               i_we       1 = store, 0 = load
//               i_lane     byte address bits [1:0]
//               i_wdata    LSB-justified store data
//               i_rword    raw 32-bit word read from the array
//               o_byte_en  per-byte write enables
//               o_wdata    store data replicated into every lane
//               o_rdata    extended load data
//               o_misalign address not aligned to access size
//               o_illegal  funct3 not valid for this direction
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import data_memory_banked_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rword[7:0];
        case (i_lane)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_byte_en  = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = 32'd0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            c_F3_B: begin
                // Replicating the data lets the enable alone pick the lane.
                o_byte_en = 4'b0001 << i_lane;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = {{24{w_byte[7]}}, w_byte};
            end
            c_F3_H: begin
                o_misalign = i_lane[0];
                o_byte_en  = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15]}}, w_half};
            end
            c_F3_W: begin
                o_misalign = (i_lane != 2'b00);
                o_byte_en  = 4'b1111;
                o_rdata    = i_rword;
            end
            c_F3_BU: begin
                o_illegal = i_we;
                o_rdata   = {24'd0, w_byte};
            end
            c_F3_HU: begin
                o_illegal  = i_we;
                o_misalign = i_lane[0];
                o_rdata    = {16'd0, w_half};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
        if (o_misalign || o_illegal) begin
            o_byte_en = 4'b0000;
        end
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_memory_banked.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_banked
// Description : MEM-stage data memory with RV32 byte/half/word access,
//               valid/ready request port, configurable wait states and a
//               single request in flight.
// Ports       : clk, rst     clock / synchronous active-high reset
//               req_valid    request present
//               req_ready    block can accept a request this cycle
//               req_we       1 = store, 0 = load
//               req_funct3   RV32 funct3
//               req_addr     byte address
//               req_wdata    LSB-justified store data
//               rsp_valid    one-cycle completion pulse
//               rsp_rdata    extended load data (0 for stores / errors)
//               rsp_err      misaligned, illegal funct3 or out of range
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_banked
    import data_memory_banked_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0,
    parameter int ZERO_WORD0  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0] ram [0:DEPTH_WORDS-1];

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_access;
    logic        w_acc_we;
    logic [2:0]  w_acc_funct3;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [c_AW-1:0] w_idx;
    logic        w_word0;
    logic        w_oor;
    logic [31:0] w_rword;
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_ld_data;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_err;
    logic        w_do_write;

    assign req_ready = (r_state == c_S_IDLE) || (r_state == c_S_RESP);
    assign w_accept  = req_valid && req_ready;

    // With no wait states the access happens on the accept edge itself, so the
    // live request is used; otherwise the latched copy drives the access.
    assign w_access     = (WAIT_STATES == 0) ? w_accept
                                             : ((r_state == c_S_BUSY) && (r_cnt == 4'd0));
    assign w_acc_we     = (WAIT_STATES == 0) ? req_we     : r_we;
    assign w_acc_funct3 = (WAIT_STATES == 0) ? req_funct3 : r_funct3;
    assign w_acc_addr   = (WAIT_STATES == 0) ? req_addr   : r_addr;
    assign w_acc_wdata  = (WAIT_STATES == 0) ? req_wdata  : r_wdata;

    assign w_idx   = w_acc_addr[c_AW+1:2];
    assign w_oor   = (w_acc_addr >> (c_AW + 2)) != 32'd0;
    assign w_word0 = (ZERO_WORD0 != 0) && (w_idx == '0);
    assign w_rword = w_word0 ? 32'd0 : ram[w_idx];

    mem_lane_align u_align (
        .i_funct3   (w_acc_funct3),
        .i_we       (w_acc_we),
        .i_lane     (w_acc_addr[1:0]),
        .i_wdata    (w_acc_wdata),
        .i_rword    (w_rword),
        .o_byte_en  (w_byte_en),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign w_err = w_misalign || w_illegal || w_oor;

    // A write landing on the reset edge is dropped along with its response.
    assign w_do_write = w_access && w_acc_we && !w_err && !w_word0 && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE, c_S_RESP: begin
                w_state_nxt = c_S_IDLE;
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = c_S_RESP;
                    end else begin
                        w_state_nxt = c_S_BUSY;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            c_S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_access;
            if (w_access) begin
                r_rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : w_ld_data;
                r_rsp_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    ram[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule : data_memory_banked
`default_nettype wire

// File: tb/tb_data_memory_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_banked
// Description : Self-checking bench for data_memory_banked. Two instances
//               share clock and reset: dut0 with no wait states, dut3 with
//               three. Expected responses are queued when a request is
//               accepted and compared when rsp_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_banked;
    import data_memory_banked_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rv0, rdy0, we0, vld0, er0;
    logic [2:0]  f3_0;
    logic [31:0] a0, wd0, rd0;
    logic        rv3, rdy3, we3, vld3, er3;
    logic [2:0]  f3_3;
    logic [31:0] a3, wd3, rd3;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    data_memory_banked #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ZERO_WORD0(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(we0),
        .req_funct3(f3_0), .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(er0));

    data_memory_banked #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ZERO_WORD0(1)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .req_we(we3),
        .req_funct3(f3_3), .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_err(er3));

    always @(posedge clk) cyc++;

    // Scoreboards: one per instance
    always @(negedge clk) begin
        if (vld0 === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL dut0_unexpected_rsp: rsp_valid=1 required 0 (rdata=%08h)", rd0);
            end else begin
                e0 = q0.pop_front();
                if (rd0 !== e0.rdata || er0 !== e0.err) begin
                    n_bad++;
                    $display("FAIL dut0_rsp: rdata=%08h err=%b required rdata=%08h err=%b",
                             rd0, er0, e0.rdata, e0.err);
                end
            end
        end
        if (vld3 === 1'b1) begin
            n_cmp++;
            if (q3.size() == 0) begin
                n_bad++;
                $display("FAIL dut3_unexpected_rsp: rsp_valid=1 required 0 (rdata=%08h)", rd3);
            end else begin
                e3 = q3.pop_front();
                if (rd3 !== e3.rdata || er3 !== e3.err) begin
                    n_bad++;
                    $display("FAIL dut3_rsp: rdata=%08h err=%b required rdata=%08h err=%b",
                             rd3, er3, e3.rdata, e3.err);
                end
            end
        end
    end

    // Drives one request on instance p, waits for acceptance, queues the
    // expected response. Entered and left at #1 after a rising edge.
    task automatic send(input int p, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
        int   t;
        exp_t x;
        x.rdata = er;
        x.err   = ee;
        if (p == 0) begin rv0 = 1'b1; we0 = we; f3_0 = f3; a0 = a; wd0 = wd; end
        else        begin rv3 = 1'b1; we3 = we; f3_3 = f3; a3 = a; wd3 = wd; end
        t = 0;
        while (((p == 0) ? rdy0 : rdy3) !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (((p == 0) ? rdy0 : rdy3) !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: dut%0d req_ready=0 required 1 within 50 cycles", p);
        end
        if (p == 0) q0.push_back(x); else q3.push_back(x);
        @(posedge clk); #1;
        if (p == 0) rv0 = 1'b0; else rv3 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q3.size() != 0) && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (q0.size() != 0 || q3.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: pending=%0d/%0d required 0/0", q0.size(), q3.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rv0 = 1'b0; we0 = 1'b0; f3_0 = 3'd0; a0 = 32'd0; wd0 = 32'd0;
        rv3 = 1'b0; we3 = 1'b0; f3_3 = 3'd0; a3 = 32'd0; wd3 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (vld0 !== 1'b0 || vld3 !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid: %b/%b required 0/0", vld0, vld3); end
        n_cmp++; if (rd0 !== 32'd0 || rd3 !== 32'd0) begin n_bad++;
            $display("FAIL reset_rdata: %08h/%08h required 0/0", rd0, rd3); end
        n_cmp++; if (er0 !== 1'b0 || er3 !== 1'b0) begin n_bad++;
            $display("FAIL reset_err: %b/%b required 0/0", er0, er3); end
        n_cmp++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready: %b/%b required 1/1", rdy0, rdy3); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        send(0, 1'b1, c_F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        n_cmp++; if (vld0 !== 1'b1) begin n_bad++;
            $display("FAIL sw_latency: rsp_valid=%b required 1 one cycle after accept", vld0); end
        send(0, 1'b0, c_F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        n_cmp++; if (vld0 !== 1'b1) begin n_bad++;
            $display("FAIL lw_latency: rsp_valid=%b required 1 one cycle after accept", vld0); end
        drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        send(0, 1'b0, c_F3_B,  32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
        send(0, 1'b0, c_F3_BU, 32'h13, 32'd0, 32'h000000DE, 1'b0);
        send(0, 1'b0, c_F3_H,  32'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
        send(0, 1'b0, c_F3_HU, 32'h10, 32'd0, 32'h0000BEEF, 1'b0);
        n_cmp++; if (cyc - c0 !== 4) begin n_bad++;
            $display("FAIL throughput: %0d cycles for 4 loads required 4", cyc - c0); end
        drain();
    endtask

    task automatic test_partial_stores();
        send(0, 1'b1, c_F3_B, 32'h11, 32'hFFFFFF55, 32'd0, 1'b0);
        send(0, 1'b0, c_F3_W, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0);
        send(0, 1'b1, c_F3_H, 32'h12, 32'hABCD1234, 32'd0, 1'b0);
        send(0, 1'b0, c_F3_W, 32'h10, 32'd0, 32'h123455EF, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        send(0, 1'b0, c_F3_W,  32'h11,  32'd0,        32'd0, 1'b1);
        send(0, 1'b1, c_F3_H,  32'h13,  32'hFFFFFFFF, 32'd0, 1'b1);
        send(0, 1'b0, c_F3_B,  32'h410, 32'd0,        32'd0, 1'b1);
        send(0, 1'b1, c_F3_W,  32'h410, 32'd0,        32'd0, 1'b1);
        send(0, 1'b0, 3'b011,  32'h10,  32'd0,        32'd0, 1'b1);
        send(0, 1'b1, c_F3_BU, 32'h10,  32'hFFFFFFFF, 32'd0, 1'b1);
        send(0, 1'b0, c_F3_W,  32'h10,  32'd0, 32'h123455EF, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rd0 !== 32'h123455EF || vld0 !== 1'b0) begin n_bad++;
            $display("FAIL rdata_hold: rdata=%08h valid=%b required 123455ef/0", rd0, vld0); end
    endtask

    task automatic test_zero_word0();
        send(0, 1'b1, c_F3_W, 32'h0, 32'hFFFFFFFF, 32'd0, 1'b0);
        send(0, 1'b0, c_F3_W, 32'h0, 32'd0,        32'd0, 1'b0);
        drain();
    endtask

    task automatic test_wait_states();
        send(3, 1'b1, c_F3_W, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
        // Hold a second request during BUSY; it must wait for req_ready.
        rv3 = 1'b1; we3 = 1'b0; f3_3 = c_F3_W; a3 = 32'h20; wd3 = 32'd0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdy3 !== 1'b0 || vld3 !== 1'b0) begin n_bad++;
                $display("FAIL busy_cycle%0d: ready=%b valid=%b required 0/0", k, rdy3, vld3); end
            @(posedge clk); #1;
        end
        n_cmp++; if (rdy3 !== 1'b1 || vld3 !== 1'b1) begin n_bad++;
            $display("FAIL ws3_resp: ready=%b valid=%b required 1/1", rdy3, vld3); end
        q3.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        @(posedge clk); #1;
        rv3 = 1'b0;
        n_cmp++; if (rdy3 !== 1'b0 || vld3 !== 1'b0) begin n_bad++;
            $display("FAIL ws3_second_accept: ready=%b valid=%b required 0/0", rdy3, vld3); end
        drain();
    endtask

    task automatic test_reset_drop();
        logic seen;
        rv3 = 1'b1; we3 = 1'b1; f3_3 = c_F3_W; a3 = 32'h20; wd3 = 32'h11111111;
        @(posedge clk); #1;
        rv3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (vld3 !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++;
            $display("FAIL reset_drop_valid: rsp_valid seen=%b required 0", seen); end
        n_cmp++; if (rdy3 !== 1'b1) begin n_bad++;
            $display("FAIL reset_drop_ready: ready=%b required 1", rdy3); end
        send(3, 1'b0, c_F3_W, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_partial_stores();
        test_errors();
        test_zero_word0();
        test_wait_states();
        test_reset_drop();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_memory_banked
`default_nettype wire
